// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, instruction-memory address and
// IF/ID pipeline register with redirect, stall, bubble and fetch counting.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        ClkIn,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  output logic [31:0] ImemAddr,
  input  logic [31:0] ImemData,
  output logic [31:0] IfId_Instr,
  output logic [31:0] IfId_PcPlus4,
  output logic        IfId_Valid,
  output logic [31:0] FetchCount
);

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_valid;
  logic [31:0] r_fetch_count;

  logic        w_redirect;
  logic [31:0] w_target_sel;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_pc_plus4;

  // A taken branch (resolved later in the pipe) outranks a jump from decode.
  assign w_redirect    = BranchTaken | Jump;
  assign w_target_sel  = BranchTaken ? BranchTarget : JumpTarget;
  assign w_redirect_pc = w_target_sel & 32'hFFFF_FFFC;
  assign w_pc_plus4    = r_pc + 32'd4;

  always_ff @(posedge ClkIn) begin
    if (Rst) begin
      r_pc          <= RESET_PC;
      r_instr       <= NOP_WORD;
      r_pc_plus4    <= 32'd0;
      r_valid       <= 1'b0;
      r_fetch_count <= 32'd0;
    end else if (w_redirect) begin
      // The word fetched this cycle is on the wrong path; replace it with a bubble.
      r_pc       <= w_redirect_pc;
      r_instr    <= NOP_WORD;
      r_pc_plus4 <= 32'd0;
      r_valid    <= 1'b0;
    end else if (!Stall) begin
      r_pc          <= w_pc_plus4;
      r_instr       <= ImemData;
      r_pc_plus4    <= w_pc_plus4;
      r_valid       <= 1'b1;
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign ImemAddr     = r_pc;
  assign IfId_Instr   = r_instr;
  assign IfId_PcPlus4 = r_pc_plus4;
  assign IfId_Valid   = r_valid;
  assign FetchCount   = r_fetch_count;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table for the corner cases followed by
// randomized control traffic checked against a behavioural fetch model.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, br, jmp;
  logic [31:0] br_tgt, jmp_tgt;
  logic [31:0] imem_addr, imem_data, ifid_instr, ifid_pc4, fetch_cnt;
  logic        ifid_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'd0) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_data = rom(imem_addr);

  if_stage #(.RESET_PC(32'h0), .NOP_WORD(NOP)) dut (
    .ClkIn(clk), .Rst(rst), .Stall(stall),
    .BranchTaken(br), .BranchTarget(br_tgt),
    .Jump(jmp), .JumpTarget(jmp_tgt),
    .ImemAddr(imem_addr), .ImemData(imem_data),
    .IfId_Instr(ifid_instr), .IfId_PcPlus4(ifid_pc4),
    .IfId_Valid(ifid_valid), .FetchCount(fetch_cnt)
  );

  typedef struct {
    logic        rst, stall, br;
    logic [31:0] brt;
    logic        jmp;
    logic [31:0] jt;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr, e_pc4, e_cnt;
  } vec_t;

  vec_t vecs[23];

  task automatic check(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%08h want=%08h", name, step, act, exp);
    end
  endtask

  task automatic drive_edge(input logic r, input logic s, input logic b, input logic [31:0] bt,
                            input logic j, input logic [31:0] jt);
    rst = r; stall = s; br = b; br_tgt = bt; jmp = j; jmp_tgt = jt;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int step, input logic [31:0] a,
                           input logic v, input logic [31:0] ins, input logic [31:0] p4,
                           input logic [31:0] c);
    check({tag, "_addr"},  step, imem_addr, a);
    check({tag, "_valid"}, step, {31'd0, ifid_valid}, {31'd0, v});
    check({tag, "_instr"}, step, ifid_instr, ins);
    check({tag, "_pc4"},   step, ifid_pc4, p4);
    check({tag, "_cnt"},   step, fetch_cnt, c);
    $display("%s %0d: addr=%08h valid=%0b instr=%08h pc4=%08h cnt=%0d",
             tag, step, imem_addr, ifid_valid, ifid_instr, ifid_pc4, fetch_cnt);
  endtask

  // Behavioural model state
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid;

  task automatic model_step(input logic r, input logic s, input logic b, input logic [31:0] bt,
                            input logic j, input logic [31:0] jt);
    logic [31:0] fetched;
    fetched = rom(m_pc);
    if (r) begin
      m_pc = 0; m_instr = NOP; m_pc4 = 0; m_valid = 0; m_cnt = 0;
    end else if (b || j) begin
      m_pc = (b ? bt : jt) / 4 * 4;
      m_instr = NOP; m_pc4 = 0; m_valid = 0;
    end else if (!s) begin
      m_instr = fetched; m_pc4 = m_pc + 4; m_pc = m_pc + 4; m_valid = 1; m_cnt = m_cnt + 1;
    end
  endtask

  initial begin
    rst = 1; stall = 0; br = 0; jmp = 0; br_tgt = 0; jmp_tgt = 0;

    //             rst stl br  brt            jmp jt             addr           v  instr             pc4            cnt
    vecs[0]  = '{0, 0, 0, 32'h0,         0, 32'h0,         32'h4,         1, 32'h2008_0005,  32'h4,         32'd1};
    vecs[1]  = '{0, 0, 0, 32'h0,         0, 32'h0,         32'h8,         1, rom(32'h4),     32'h8,         32'd2};
    vecs[2]  = '{0, 0, 0, 32'h0,         0, 32'h0,         32'hC,         1, rom(32'h8),     32'hC,         32'd3};
    vecs[3]  = '{0, 0, 0, 32'h0,         0, 32'h0,         32'h10,        1, rom(32'hC),     32'h10,        32'd4};
    vecs[4]  = '{0, 1, 0, 32'h0,         0, 32'h0,         32'h10,        1, rom(32'hC),     32'h10,        32'd4};
    vecs[5]  = '{0, 1, 0, 32'h0,         0, 32'h0,         32'h10,        1, rom(32'hC),     32'h10,        32'd4};
    vecs[6]  = '{0, 1, 0, 32'h0,         0, 32'h0,         32'h10,        1, rom(32'hC),     32'h10,        32'd4};
    vecs[7]  = '{0, 0, 0, 32'h0,         0, 32'h0,         32'h14,        1, rom(32'h10),    32'h14,        32'd5};
    vecs[8]  = '{0, 0, 0, 32'h0,         0, 32'h0,         32'h18,        1, rom(32'h14),    32'h18,        32'd6};
    vecs[9]  = '{0, 0, 0, 32'h0,         0, 32'h0,         32'h1C,        1, rom(32'h18),    32'h1C,        32'd7};
    vecs[10] = '{0, 0, 0, 32'h0,         0, 32'h0,         32'h20,        1, rom(32'h1C),    32'h20,        32'd8};
    vecs[11] = '{0, 1, 1, 32'h47,        1, 32'h100,       32'h44,        0, NOP,            32'h0,         32'd8};
    vecs[12] = '{0, 0, 0, 32'h0,         0, 32'h0,         32'h48,        1, rom(32'h44),    32'h48,        32'd9};
    vecs[13] = '{0, 0, 0, 32'h0,         1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 0, NOP,            32'h0,         32'd9};
    vecs[14] = '{0, 0, 0, 32'h0,         0, 32'h0,         32'h0,         1, rom(32'hFFFF_FFFC), 32'h0,     32'd10};
    vecs[15] = '{0, 0, 0, 32'h0,         0, 32'h0,         32'h4,         1, 32'h2008_0005,  32'h4,         32'd11};
    vecs[16] = '{0, 0, 0, 32'h0,         1, 32'h32,        32'h30,        0, NOP,            32'h0,         32'd11};
    vecs[17] = '{0, 1, 0, 32'h0,         0, 32'h0,         32'h30,        0, NOP,            32'h0,         32'd11};
    vecs[18] = '{1, 1, 0, 32'h0,         0, 32'h0,         32'h0,         0, NOP,            32'h0,         32'd0};
    vecs[19] = '{0, 0, 0, 32'h0,         0, 32'h0,         32'h4,         1, 32'h2008_0005,  32'h4,         32'd1};
    vecs[20] = '{0, 1, 0, 32'h0,         1, 32'h81,        32'h80,        0, NOP,            32'h0,         32'd1};
    vecs[21] = '{0, 1, 0, 32'h0,         0, 32'h0,         32'h80,        0, NOP,            32'h0,         32'd1};
    vecs[22] = '{0, 0, 0, 32'h0,         0, 32'h0,         32'h84,        1, rom(32'h80),    32'h84,        32'd2};

    // Reset held for 8 edges: outputs pinned to reset values throughout
    for (int i = 0; i < 8; i++) begin
      drive_edge(1, 0, 0, 0, 0, 0);
      check_all("rst", i, 32'h0, 1'b0, NOP, 32'h0, 32'h0);
    end

    for (int i = 0; i < 23; i++) begin
      drive_edge(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].brt, vecs[i].jmp, vecs[i].jt);
      check_all("vec", i, vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_instr,
                vecs[i].e_pc4, vecs[i].e_cnt);
    end

    // Randomized control traffic against the model, starting from a clean reset
    drive_edge(1, 0, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      logic r, s, b, j;
      logic [31:0] bt, jt;
      r  = ($urandom_range(0, 99) < 2);
      s  = ($urandom_range(0, 99) < 25);
      b  = ($urandom_range(0, 99) < 8);
      j  = ($urandom_range(0, 99) < 8);
      bt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      jt = $urandom;
      model_step(r, s, b, bt, j, jt);
      drive_edge(r, s, b, bt, j, jt);
      check_all("rnd", i, m_pc, m_valid, m_instr, m_pc4, m_cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the MIPS CPU: holds the program counter, drives the instruction-memory address, and captures the fetched word plus PC+4 into the IF/ID pipeline register consumed by the decode stage inside `top`. It applies redirects from branch resolution and jump decode, honours load-use stalls from the hazard unit, and inserts bubbles on flush. A free-running fetch counter supports bench checks and performance readout.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset.
- `NOP_WORD`, default `32'h0000_0000`: instruction word inserted as a bubble (`sll $0,$0,0`).
- `ClkIn  in  1`: single clock. All state updates on the rising edge.
- `Rst  in  1`: synchronous, active-high reset, sampled on the rising edge of `ClkIn`.
- `Stall  in  1`: hazard-unit stall. Hold the PC and IF/ID.
- `BranchTaken  in  1`: branch resolved taken (EX). Redirect and flush.
- `BranchTarget  in  32`: branch target address.
- `Jump  in  1`: jump decoded (ID). Redirect and flush.
- `JumpTarget  in  32`: jump target address.
- `ImemAddr  out  32`: instruction-memory word address, combinational and equal to `PC`.
- `ImemData  in  32`: instruction word. The memory is asynchronous-read and valid in the same cycle as `ImemAddr`.
- `IfId_Instr  out  32`: registered instruction for decode.
- `IfId_PcPlus4  out  32`: registered PC+4 of that instruction.
- `IfId_Valid  out  1`: 1 when IF/ID holds a real fetched instruction, 0 when it holds a bubble.
- `FetchCount  out  32`: number of instructions written into IF/ID as valid.

## Operation
- State: `PC[31:0]`, the IF/ID register (`Instr`, `PcPlus4`, `Valid`) and `FetchCount`.
- Each rising edge evaluates one case, in strict priority order:
  1. **`Rst`**: `PC`←`RESET_PC`, `IfId_Instr`←`NOP_WORD`, `IfId_PcPlus4`←0, `IfId_Valid`←0, `FetchCount`←0.
  2. **`BranchTaken`**: `PC`←{`BranchTarget[31:2]`,2'b00}. IF/ID←bubble (`NOP_WORD`, `PcPlus4`=0, `Valid`=0). Overrides `Stall` and `Jump`.
  3. **`Jump`**: `PC`←{`JumpTarget[31:2]`,2'b00}. IF/ID←bubble. Overrides `Stall`.
  4. **`Stall`**: `PC`, IF/ID and `FetchCount` all hold.
  5. **Otherwise**:
     - `PC`←`PC`+4.
     - `IfId_Instr`←`ImemData`, `IfId_PcPlus4`←`PC`+4, `IfId_Valid`←1.
     - `FetchCount`←`FetchCount`+1.
- Arithmetic:
  - All PC arithmetic is 32-bit unsigned modulo 2^32: `32'hFFFF_FFFC`+4 = 0, and `IfId_PcPlus4` also wraps to 0.
  - `FetchCount` wraps from `32'hFFFF_FFFF` to 0.
- Target low bits [1:0] are always forced to 0, so `PC[1:0]` is never nonzero.
- Bubbles never increment `FetchCount`.

## Timing
- Reset values (all outputs):
  - `ImemAddr`=`RESET_PC`, `IfId_Instr`=`NOP_WORD`, `IfId_PcPlus4`=0, `IfId_Valid`=0, `FetchCount`=0.
  - These hold for every edge at which `Rst`=1.
- Fetch latency:
  - The first edge with `Rst`=0 captures the word at `RESET_PC` into IF/ID.
  - On that same edge `ImemAddr` becomes `RESET_PC`+4.
- Redirect latency:
  - The edge that samples `BranchTaken` or `Jump` loads the target into `PC` and bubbles IF/ID.
  - The target instruction appears in IF/ID on the next non-stalled edge, giving exactly one bubble per redirect.
- Stall: while `Stall`=1 with no redirect, outputs are frozen and `ImemAddr` is stable.
- Simultaneous events:
  - `BranchTaken`+`Jump` takes the branch.
  - A redirect together with `Stall` takes the redirect; the stall is discarded.
  - Reset takes precedence over everything.
- Reset mid-operation: reset asserted at any edge (including during a stall or redirect) discards all in-flight state. No partial update survives.
- `ImemData` must be settled before each rising edge. No registered memory latency is assumed.

## Test plan
- **Reset release:** hold `Rst`=1 for 8 cycles, then release with ROM word0=`32'h2008_0005`.
  - During reset, `ImemAddr`=0 and `IfId_Valid`=0.
  - After the first edge with `Rst`=0: `IfId_Instr`=`32'h2008_0005`, `IfId_PcPlus4`=4, `ImemAddr`=4, `FetchCount`=1.
- **Sequential run:** 10 unstalled cycles from reset.
  - `ImemAddr` steps 0,4,…,40.
  - `FetchCount`=10.
  - `IfId_PcPlus4` always equals captured address+4.
- **Stall:** assert `Stall` for 3 cycles with PC=`32'h10`.
  - `ImemAddr` stays `32'h10` and IF/ID is unchanged.
  - `FetchCount` is unchanged.
  - The next fetch after release captures the word at `32'h10`.
- **Branch versus stall and jump:** at PC=`32'h20`, assert `BranchTaken`, `BranchTarget`=`32'h0000_0047`, `Jump`=1 and `Stall`=1 together.
  - Next cycle: `ImemAddr`=`32'h44`, `IfId_Valid`=0, `IfId_Instr`=`NOP_WORD`.
  - The following cycle: the word at `32'h44` is captured with `Valid`=1.
- **Wrap-around:** jump to `32'hFFFF_FFFC`.
  - The next fetch yields `IfId_PcPlus4`=0 and `ImemAddr`=0.
- **Mid-stall reset:** assert `Rst` for one edge while `Stall`=1 at PC=`32'h30`.
  - All outputs return to their reset values.
  - Fetch then restarts at `RESET_PC`.
